// File: rtl/blink_pkg.sv
// Shared constants and FSM state encodings for the blink pattern sequencer.
package blink_pkg;

   localparam int unsigned PAT_W             = 8;
   localparam int unsigned STEP_W            = 3;
   localparam int unsigned RATE_W            = 2;
   localparam int unsigned STATE_W           = 2;
   localparam int unsigned TICK_BIT_BASE_DEF = 12;

   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
   localparam logic [STATE_W-1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/tick_edge_detect.sv
// Selects one count bit by rate and emits a one-cycle tick on its rising edge.
module tick_edge_detect
   import blink_pkg::*;
#(
   parameter int unsigned COUNT_W       = 16,
   parameter int unsigned TICK_BIT_BASE = TICK_BIT_BASE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COUNT_W-1:0] current_count,
   input  logic [RATE_W-1:0]  rate,
   output logic               tick_c
);

   localparam int unsigned NSEL = 1 << RATE_W;

   logic [NSEL-1:0]    cand_c;
   logic               sel_c;
   logic               prev_q;
   logic               primed_q;
   logic [COUNT_W-1:0] unused_bits;

   assign cand_c      = current_count[TICK_BIT_BASE +: NSEL];
   assign sel_c       = cand_c[rate];
   assign unused_bits = current_count & ~(COUNT_W'(NSEL'('1)) << TICK_BIT_BASE);

   // primed_q suppresses a tick on the first cycle out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q   <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         prev_q   <= sel_c;
         primed_q <= 1'b1;
      end
   end

   assign tick_c = sel_c & ~prev_q & primed_q;

endmodule

// File: rtl/blink_pattern_seq.sv
// Plays an 8-bit pattern MSB first on blink_out, one bit per tick, with a low gap between repeats.
module blink_pattern_seq
   import blink_pkg::*;
#(
   parameter int unsigned COUNT_W       = 16,
   parameter int unsigned TICK_BIT_BASE = TICK_BIT_BASE_DEF,
   parameter int unsigned GAP_TICKS     = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [COUNT_W-1:0] current_count,
   input  logic               load,
   input  logic [PAT_W-1:0]   pattern_in,
   input  logic [RATE_W-1:0]  rate_sel,
   output logic               blink_out,
   output logic               busy,
   output logic [STEP_W-1:0]  step_idx,
   output logic               applied
);

   localparam int unsigned GAP_W = $clog2(GAP_TICKS + 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic               blink_q, blink_d;
   logic               busy_q, busy_d;
   logic [STEP_W-1:0]  step_q, step_d;
   logic               applied_q, applied_d;
   logic [PAT_W-1:0]   active_q, active_d;
   logic [RATE_W-1:0]  rate_q, rate_d;
   logic [PAT_W-1:0]   pend_q, pend_d;
   logic [RATE_W-1:0]  pend_rate_q, pend_rate_d;
   logic               pend_valid_q, pend_valid_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [PAT_W-1:0]   next_active_c;
   logic               tick_c;

   tick_edge_detect #(
      .COUNT_W       (COUNT_W),
      .TICK_BIT_BASE (TICK_BIT_BASE)
   ) u_tick (
      .clk           (clk),
      .rst           (rst),
      .current_count (current_count),
      .rate          (rate_q),
      .tick_c        (tick_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         blink_q      <= 1'b0;
         busy_q       <= 1'b0;
         step_q       <= STEP_W'(7);
         applied_q    <= 1'b0;
         active_q     <= '0;
         rate_q       <= '0;
         pend_q       <= '0;
         pend_rate_q  <= '0;
         pend_valid_q <= 1'b0;
         gap_q        <= '0;
      end else begin
         state_q      <= state_d;
         blink_q      <= blink_d;
         busy_q       <= busy_d;
         step_q       <= step_d;
         applied_q    <= applied_d;
         active_q     <= active_d;
         rate_q       <= rate_d;
         pend_q       <= pend_d;
         pend_rate_q  <= pend_rate_d;
         pend_valid_q <= pend_valid_d;
         gap_q        <= gap_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      blink_d       = blink_q;
      step_d        = step_q;
      applied_d     = 1'b0;
      active_d      = active_q;
      rate_d        = rate_q;
      pend_d        = pend_q;
      pend_rate_d   = pend_rate_q;
      pend_valid_d  = pend_valid_q;
      gap_d         = gap_q;
      next_active_c = pend_valid_q ? pend_q : active_q;

      case (state_q)
         ST_RUN: begin
            if (tick_c) begin
               blink_d = active_q[step_q];
               step_d  = STEP_W'(step_q - STEP_W'(1));
               if (step_q == '0) begin
                  state_d = ST_GAP;
                  gap_d   = GAP_W'(GAP_TICKS);
               end
            end
         end
         ST_GAP: begin
            if (tick_c) begin
               blink_d = 1'b0;
               gap_d   = GAP_W'(gap_q - GAP_W'(1));
               if (gap_q == GAP_W'(1)) begin
                  if (pend_valid_q) begin
                     active_d     = pend_q;
                     rate_d       = pend_rate_q;
                     applied_d    = 1'b1;
                     pend_valid_d = 1'b0;
                  end
                  if (next_active_c == '0) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d = ST_RUN;
                     step_d  = STEP_W'(7);
                  end
               end
            end
         end
         default: begin
            blink_d = 1'b0;
            if (load && (pattern_in != '0)) begin
               active_d = pattern_in;
               rate_d   = rate_sel;
               step_d   = STEP_W'(7);
               state_d  = ST_RUN;
            end
         end
      endcase

      // A load while playing is queued; it lands after any GAP-end apply above
      if (load && (state_q != ST_IDLE)) begin
         pend_d       = pattern_in;
         pend_rate_d  = rate_sel;
         pend_valid_d = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign blink_out = blink_q;
   assign busy      = busy_q;
   assign step_idx  = step_q;
   assign applied   = applied_q;

endmodule

// File: tb/tb_blink_pattern_seq.sv
// Bench for blink_pattern_seq: a repetition-position reference model compared every cycle.
module tb_blink_pattern_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cnt = 16'h1000;
   logic        load = 1'b0;
   logic [7:0]  pat = 8'h00;
   logic [1:0]  rsel = 2'd0;
   logic        blink_out, busy, applied;
   logic [2:0]  step_idx;

   int checks = 0;
   int passed = 0;

   // reference model: position within a 12-tick repetition (8 bits + 4 gap ticks)
   bit         m_play, m_prev, m_primed, m_out, m_app, m_pv, rnd_cnt;
   int         m_pos;
   logic [7:0] m_pat, m_pend;
   logic [1:0] m_rate, m_prate;

   blink_pattern_seq dut (
      .clk           (clk),
      .rst           (rst),
      .current_count (cnt),
      .load          (load),
      .pattern_in    (pat),
      .rate_sel      (rsel),
      .blink_out     (blink_out),
      .busy          (busy),
      .step_idx      (step_idx),
      .applied       (applied)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] obs_vec();
      return {blink_out, busy, step_idx, applied};
   endfunction

   function automatic logic [5:0] exp_vec();
      logic [2:0] s;
      s = (m_play && m_pos < 8) ? 3'(7 - m_pos) : 3'd7;
      return {m_out, m_play, s, m_app};
   endfunction

   task automatic model_reset();
      m_play = 0; m_prev = 0; m_primed = 0; m_out = 0; m_app = 0; m_pv = 0;
      m_pos = 0; m_pat = 0; m_pend = 0; m_rate = 0; m_prate = 0;
   endtask

   task automatic model_edge(input logic ld, input logic [7:0] p, input logic [1:0] rs);
      bit sel, tick;
      sel      = cnt[12 + m_rate];
      tick     = sel && !m_prev && m_primed;
      m_prev   = sel;
      m_primed = 1;
      m_app    = 0;
      if (!m_play) begin
         m_out = 0;
         if (ld && p != 0) begin
            m_pat = p; m_rate = rs; m_pos = 0; m_play = 1;
         end
      end else begin
         if (tick) begin
            m_out = (m_pos < 8) ? m_pat[7 - m_pos] : 1'b0;
            m_pos++;
            if (m_pos == 12) begin
               if (m_pv) begin
                  m_pat = m_pend; m_rate = m_prate; m_app = 1; m_pv = 0;
               end
               m_pos = 0;
               if (m_pat == 0) m_play = 0;
            end
         end
         if (ld) begin
            m_pend = p; m_prate = rs; m_pv = 1;
         end
      end
   endtask

   task automatic step(input logic ld, input logic [7:0] p, input logic [1:0] rs);
      if (rnd_cnt && $urandom_range(2) == 0) cnt = 16'($urandom);
      load = ld; pat = p; rsel = rs;
      @(posedge clk);
      model_edge(ld, p, rs);
      @(negedge clk);
      load = 1'b0;
   endtask

   // two low cycles on bit12, then a rising edge carrying the given load
   task automatic pulse(input logic ld, input logic [7:0] p, input logic [1:0] rs);
      cnt = 16'h0000;
      step(1'b0, 8'h00, 2'd0);
      step(1'b0, 8'h00, 2'd0);
      cnt = 16'h1000;
      step(ld, p, rs);
   endtask

   task automatic test_reset();
      model_reset();
      rst = 1'b1; cnt = 16'h1000;
      repeat (2) @(negedge clk);
      checks++;
      if (obs_vec() !== 6'b0_0_111_0) $display("FAIL reset_hold got %b exp %b", obs_vec(), 6'b0_0_111_0);
      else passed++;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00, 2'd0);
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL reset_release cyc %0d got %b exp %b", i, obs_vec(), exp_vec());
         else passed++;
      end
   endtask

   task automatic test_pattern();
      logic [11:0] seq;
      seq = 12'b1010_0101_0000;
      cnt = 16'h0000;
      step(1'b1, 8'hA5, 2'd0);
      checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL a5_load got %b exp %b", obs_vec(), exp_vec());
      else passed++;
      for (int i = 0; i < 24; i++) begin
         pulse(1'b0, 8'h00, 2'd0);
         checks++;
         if (blink_out !== seq[11 - (i % 12)] || obs_vec() !== exp_vec())
            $display("FAIL a5_tick %0d got %b exp %b bit %b", i, obs_vec(), exp_vec(), seq[11 - (i % 12)]);
         else passed++;
      end
   endtask

   task automatic test_stop();
      int apps = 0;
      for (int i = 0; i < 3; i++) pulse(1'b0, 8'h00, 2'd0);
      step(1'b1, 8'h00, 2'd0);
      for (int i = 0; i < 12; i++) begin
         pulse(1'b0, 8'h00, 2'd0);
         if (applied === 1'b1) apps++;
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL stop_tick %0d got %b exp %b", i, obs_vec(), exp_vec());
         else passed++;
      end
      checks++;
      if (apps !== 1 || busy !== 1'b0 || blink_out !== 1'b0)
         $display("FAIL stop_end applied=%0d busy=%b out=%b exp 1 0 0", apps, busy, blink_out);
      else passed++;
   endtask

   task automatic test_overwrite();
      int apps = 0;
      logic [7:0] nxt;
      nxt = 8'h0F;
      cnt = 16'h0000;
      step(1'b1, 8'hFF, 2'd0);
      for (int i = 0; i < 2; i++) pulse(1'b0, 8'h00, 2'd0);
      step(1'b1, 8'hF0, 2'd1);
      for (int i = 0; i < 2; i++) pulse(1'b0, 8'h00, 2'd0);
      step(1'b1, 8'h0F, 2'd0);
      for (int i = 0; i < 20; i++) begin
         pulse(1'b0, 8'h00, 2'd0);
         if (applied === 1'b1) apps++;
         checks++;
         if (obs_vec() !== exp_vec() || (i >= 8 && i < 16 && blink_out !== nxt[15 - i]))
            $display("FAIL overwrite_tick %0d got %b exp %b", i, obs_vec(), exp_vec());
         else passed++;
      end
      checks++;
      if (apps !== 1) $display("FAIL overwrite_applied count %0d exp 1", apps);
      else passed++;
      step(1'b1, 8'h00, 2'd0);
      for (int i = 0; i < 12; i++) pulse(1'b0, 8'h00, 2'd0);
      checks++;
      if (busy !== 1'b0 || obs_vec() !== exp_vec()) $display("FAIL overwrite_stop got %b exp %b", obs_vec(), exp_vec());
      else passed++;
   endtask

   task automatic test_rate3();
      logic [15:0] seq [8];
      seq = '{16'h8000, 16'hFFFF, 16'h0000, 16'h1000, 16'h0000, 16'h7FFF, 16'h8000, 16'h0000};
      cnt = 16'h0000;
      step(1'b1, 8'hC3, 2'd3);
      step(1'b0, 8'h00, 2'd0);
      for (int i = 0; i < 8; i++) begin
         cnt = seq[i];
         step(1'b0, 8'h00, 2'd0);
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL rate3 cyc %0d got %b exp %b", i, obs_vec(), exp_vec());
         else passed++;
         if (i == 5) begin
            checks++;
            if (step_idx !== 3'd6) $display("FAIL rate3_wrap step_idx %0d exp 6", step_idx);
            else passed++;
         end
      end
      checks++;
      if (step_idx !== 3'd5 || blink_out !== 1'b1) $display("FAIL rate3_second step_idx %0d out %b exp 5 1", step_idx, blink_out);
      else passed++;
   endtask

   task automatic test_random();
      logic       ld;
      logic [7:0] p;
      rnd_cnt = 1;
      for (int i = 0; i < 2000; i++) begin
         ld = ($urandom_range(15) == 0);
         p  = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
         step(ld, p, 2'($urandom));
         checks++;
         if (obs_vec() !== exp_vec()) $display("FAIL random cyc %0d got %b exp %b", i, obs_vec(), exp_vec());
         else passed++;
      end
      rnd_cnt = 0;
   endtask

   task automatic test_reset_mid();
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      cnt = 16'h0000;
      step(1'b1, 8'h55, 2'd0);
      for (int i = 0; i < 9; i++) pulse(1'b0, 8'h00, 2'd0);
      step(1'b1, 8'h3C, 2'd1);
      pulse(1'b0, 8'h00, 2'd0);
      checks++;
      if (busy !== 1'b1 || obs_vec() !== exp_vec()) $display("FAIL gap_before_reset got %b exp %b", obs_vec(), exp_vec());
      else passed++;
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks++;
      if (obs_vec() !== 6'b0_0_111_0) $display("FAIL async_reset got %b exp %b", obs_vec(), 6'b0_0_111_0);
      else passed++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         pulse(1'b0, 8'h00, 2'd0);
         checks++;
         if (busy !== 1'b0 || obs_vec() !== exp_vec()) $display("FAIL after_reset tick %0d got %b exp %b", i, obs_vec(), exp_vec());
         else passed++;
      end
   endtask

   initial begin
      rnd_cnt = 0;
      test_reset();
      test_pattern();
      test_stop();
      test_overwrite();
      test_rate3();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
